// File: rtl/rds_pkg.sv
// Shared types, defaults and the per-component clip helper for the 3DRS candidate engine.
package rds_pkg;

  localparam int MV_W_DEF  = 7;
  localparam int SAD_W_DEF = 16;

  // Motion vector at the default width, packed as {y, x}
  typedef struct packed {
    logic signed [MV_W_DEF-1:0] y;
    logic signed [MV_W_DEF-1:0] x;
  } mv_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_EXT,
    ST_DONE
  } state_t;

  // Saturate one MV component to the symmetric search window [-r, +r]
  function automatic int clip_comp(input int v, input int r);
    if (v > r) begin
      return r;
    end else if (v < -r) begin
      return -r;
    end
    return v;
  endfunction

endpackage

// File: rtl/rds_mv_clip.sv
// Combinational add of a base MV and an offset MV, then per-component clip to the search window.
// The sum is formed one bit wider than a component so it can never wrap before clipping.
module rds_mv_clip
  import rds_pkg::*;
#(
  parameter int MV_W   = MV_W_DEF,
  parameter int SRCH_R = 16
) (
  input  logic [2*MV_W-1:0] base,
  input  logic [2*MV_W-1:0] delta,
  output logic [2*MV_W-1:0] mv
);

  logic signed [MV_W:0]   sum_x;
  logic signed [MV_W:0]   sum_y;
  logic signed [MV_W-1:0] clip_x;
  logic signed [MV_W-1:0] clip_y;

  // Widen, add and saturate each component independently
  always_comb begin
    sum_x  = $signed({base[MV_W-1], base[MV_W-1:0]}) +
             $signed({delta[MV_W-1], delta[MV_W-1:0]});
    sum_y  = $signed({base[2*MV_W-1], base[2*MV_W-1:MV_W]}) +
             $signed({delta[2*MV_W-1], delta[2*MV_W-1:MV_W]});
    clip_x = MV_W'(clip_comp(int'(sum_x), SRCH_R));
    clip_y = MV_W'(clip_comp(int'(sum_y), SRCH_R));
    mv     = {clip_y, clip_x};
  end

endmodule

// File: rtl/rds_cand_engine.sv
// 3DRS candidate evaluation engine: builds and clips the candidate list for a block, streams it
// to the SAD array, tracks the lowest SAD and optionally runs a +/-1 refinement pass around it.
module rds_cand_engine
  import rds_pkg::*;
#(
  parameter int MV_W    = MV_W_DEF,
  parameter int SAD_W   = SAD_W_DEF,
  parameter int NUM_UPD = 2,
  parameter int SRCH_R  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      first_frame,
  input  logic                      ext_en,
  input  logic [SAD_W-1:0]          sad_th,
  input  logic [2*MV_W-1:0]         cand_sp_a,
  input  logic [2*MV_W-1:0]         cand_sp_b,
  input  logic [2*MV_W-1:0]         cand_tmp,
  input  logic [NUM_UPD*2*MV_W-1:0] upd_vec,
  output logic                      cand_valid,
  input  logic                      cand_ready,
  output logic [2*MV_W-1:0]         cand_mv,
  input  logic                      sad_valid,
  input  logic [SAD_W-1:0]          sad_in,
  output logic                      busy,
  output logic                      done,
  output logic [2*MV_W-1:0]         mv_out,
  output logic [SAD_W-1:0]          sad_out,
  output logic                      under_th,
  output logic                      extended
);

  localparam int MVB    = 2 * MV_W;
  localparam int NBASE  = 3 + NUM_UPD;
  localparam int LIST_N = (NBASE > 4) ? NBASE : 4;
  localparam int CW     = $clog2(LIST_N + 1);

  localparam logic [MV_W-1:0] OFS_Z = '0;
  localparam logic [MV_W-1:0] OFS_P = MV_W'(1);
  localparam logic [MV_W-1:0] OFS_M = {MV_W{1'b1}};

  state_t state;
  state_t state_nx;

  // Inputs captured at start so the caller may change them during the block
  logic [MVB-1:0]         sp_a_q;
  logic [MVB-1:0]         sp_b_q;
  logic [MVB-1:0]         tmp_q;
  logic [NUM_UPD*MVB-1:0] upd_q;
  logic                   ff_q;
  logic                   ext_en_q;
  logic [SAD_W-1:0]       th_q;

  logic [MVB-1:0] cand_q    [LIST_N];
  logic [MVB-1:0] src_base  [LIST_N];
  logic [MVB-1:0] src_delta [LIST_N];
  logic [MVB-1:0] clip_out  [LIST_N];

  logic [CW-1:0]    list_len;
  logic [CW-1:0]    issue_cnt;
  logic [CW-1:0]    ret_cnt;
  logic             ext_done;
  logic             best_vld;
  logic [MVB-1:0]   best_mv;
  logic [SAD_W-1:0] best_sad;

  logic [MVB-1:0] issue_mv;
  logic [MVB-1:0] ret_mv;
  logic           xfer;
  logic           ret_ok;
  logic           last_issue;

  assign cand_valid = (state == ST_ISSUE);
  assign cand_mv    = cand_valid ? issue_mv : '0;
  assign busy       = (state != ST_IDLE);
  assign xfer       = cand_valid && cand_ready;
  assign ret_ok     = sad_valid && ((state == ST_ISSUE) || (state == ST_DRAIN)) &&
                      (ret_cnt < issue_cnt);
  assign last_issue = (issue_cnt == list_len - CW'(1));

  // Clipper inputs: the base list in LOAD, the four +/-1 neighbours of the best MV in EXT.
  // Update candidates are offsets from sp_a after first_frame forcing, so they become the raw
  // update vectors on the first frame.
  always_comb begin
    for (int k = 0; k < LIST_N; k++) begin
      src_base[k]  = '0;
      src_delta[k] = '0;
    end
    if (state == ST_EXT) begin
      for (int k = 0; k < 4; k++) begin
        src_base[k] = best_mv;
      end
      src_delta[0] = {OFS_Z, OFS_P};
      src_delta[1] = {OFS_Z, OFS_M};
      src_delta[2] = {OFS_P, OFS_Z};
      src_delta[3] = {OFS_M, OFS_Z};
    end else begin
      src_base[0] = ff_q ? '0 : sp_a_q;
      src_base[1] = ff_q ? '0 : sp_b_q;
      src_base[2] = ff_q ? '0 : tmp_q;
      for (int k = 0; k < NUM_UPD; k++) begin
        src_base[3+k]  = ff_q ? '0 : sp_a_q;
        src_delta[3+k] = upd_q[k*MVB +: MVB];
      end
    end
  end

  for (genvar g = 0; g < LIST_N; g++) begin : g_clip
    rds_mv_clip #(
      .MV_W  (MV_W),
      .SRCH_R(SRCH_R)
    ) u_clip (
      .base (src_base[g]),
      .delta(src_delta[g]),
      .mv   (clip_out[g])
    );
  end

  // Select the list entries addressed by the issue and return counters
  always_comb begin
    issue_mv = '0;
    ret_mv   = '0;
    for (int k = 0; k < LIST_N; k++) begin
      if (issue_cnt == CW'(k)) issue_mv = cand_q[k];
      if (ret_cnt == CW'(k))   ret_mv   = cand_q[k];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DRAIN waits for every issued candidate to be costed
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_ISSUE;
      ST_ISSUE: if (xfer && last_issue) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (ret_cnt == issue_cnt) begin
          if ((best_sad >= th_q) && ext_en_q && !ext_done) state_nx = ST_EXT;
          else                                            state_nx = ST_DONE;
        end
      end
      ST_EXT:   state_nx = ST_ISSUE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Input capture, candidate list, issue/return counters and best-candidate tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_a_q    <= '0;
      sp_b_q    <= '0;
      tmp_q     <= '0;
      upd_q     <= '0;
      ff_q      <= 1'b0;
      ext_en_q  <= 1'b0;
      th_q      <= '0;
      for (int k = 0; k < LIST_N; k++) cand_q[k] <= '0;
      list_len  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      ext_done  <= 1'b0;
      best_vld  <= 1'b0;
      best_mv   <= '0;
      best_sad  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sp_a_q   <= cand_sp_a;
            sp_b_q   <= cand_sp_b;
            tmp_q    <= cand_tmp;
            upd_q    <= upd_vec;
            ff_q     <= first_frame;
            ext_en_q <= ext_en;
            th_q     <= sad_th;
            ext_done <= 1'b0;
            best_vld <= 1'b0;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < LIST_N; k++) cand_q[k] <= clip_out[k];
          list_len  <= CW'(NBASE);
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
        ST_EXT: begin
          for (int k = 0; k < 4; k++) cand_q[k] <= clip_out[k];
          list_len  <= CW'(4);
          issue_cnt <= '0;
          ret_cnt   <= '0;
          ext_done  <= 1'b1;
        end
        default: begin
          if (xfer) issue_cnt <= issue_cnt + CW'(1);
          if (ret_ok) begin
            ret_cnt <= ret_cnt + CW'(1);
            // Strict less-than: on a tie the earlier candidate stays best
            if (!best_vld || (sad_in < best_sad)) begin
              best_mv  <= ret_mv;
              best_sad <= sad_in;
            end
            best_vld <= 1'b1;
          end
        end
      endcase
    end
  end

  // Result registers, loaded as the block completes; done is a single-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      mv_out   <= '0;
      sad_out  <= '0;
      under_th <= 1'b0;
      extended <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == ST_DRAIN) && (state_nx == ST_DONE)) begin
        done     <= 1'b1;
        mv_out   <= best_mv;
        sad_out  <= best_sad;
        under_th <= (best_sad < th_q);
        extended <= ext_done;
      end
    end
  end

endmodule

// File: tb/tb_rds_cand_engine.sv
// Scoreboard bench for rds_cand_engine: stimulus pushes expected candidates and results,
// a SAD responder returns planned costs with latency 2, and a monitor pops and compares.
module tb_rds_cand_engine;
  import rds_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        first_frame;
  logic        ext_en;
  logic [15:0] sad_th;
  logic [13:0] cand_sp_a;
  logic [13:0] cand_sp_b;
  logic [13:0] cand_tmp;
  logic [27:0] upd_vec;
  logic        cand_valid;
  logic        cand_ready;
  logic [13:0] cand_mv;
  logic        sad_valid;
  logic [15:0] sad_in;
  logic        busy;
  logic        done;
  logic [13:0] mv_out;
  logic [15:0] sad_out;
  logic        under_th;
  logic        extended;

  rds_cand_engine #(
    .MV_W   (7),
    .SAD_W  (16),
    .NUM_UPD(2),
    .SRCH_R (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_frame(first_frame),
    .ext_en     (ext_en),
    .sad_th     (sad_th),
    .cand_sp_a  (cand_sp_a),
    .cand_sp_b  (cand_sp_b),
    .cand_tmp   (cand_tmp),
    .upd_vec    (upd_vec),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_mv    (cand_mv),
    .sad_valid  (sad_valid),
    .sad_in     (sad_in),
    .busy       (busy),
    .done       (done),
    .mv_out     (mv_out),
    .sad_out    (sad_out),
    .under_th   (under_th),
    .extended   (extended)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] mv;
    logic [15:0] sad;
    logic        under;
    logic        ext;
    int          lat;
  } res_t;

  logic [13:0] exp_cand_q[$];
  logic [15:0] sad_plan[$];
  res_t        exp_res_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int st_cyc = 0;
  bit rand_ready = 1'b0;

  bit          p0_v = 1'b0;
  bit          p1_v = 1'b0;
  logic [15:0] p0_d = '0;
  logic [15:0] p1_d = '0;

  function automatic logic [13:0] mv(input int x, input int y);
    mv_t m;
    m.x = 7'(x);
    m.y = 7'(y);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SAD array model: ready (optionally random) and in-order costs returned two edges after transfer
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      p0_v = 1'b0;
      p1_v = 1'b0;
      sad_valid = 1'b0;
      sad_in = '0;
      cand_ready = 1'b1;
    end else begin
      cand_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      sad_valid = p1_v;
      sad_in = p1_d;
      p1_v = p0_v;
      p1_d = p0_d;
      p0_v = cand_valid && cand_ready;
      p0_d = 16'hFFFF;
      if (p0_v && (sad_plan.size() > 0)) p0_d = sad_plan.pop_front();
    end
  end

  // Monitor: candidate transfers, stall stability and block results
  always @(negedge clk) begin
    if (reset) begin
      if (cand_valid) begin
        if (exp_cand_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cand_unexpected: got cand_mv 0x%0h, expected no candidate", cand_mv);
        end else if (cand_ready) begin
          chk("cand_mv", 32'(cand_mv), 32'(exp_cand_q.pop_front()));
        end else begin
          chk("cand_stall_hold", 32'(cand_mv), 32'(exp_cand_q[0]));
        end
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got done=1 mv_out=0x%0h, expected no done", mv_out);
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          chk("mv_out", 32'(mv_out), 32'(r.mv));
          chk("sad_out", 32'(sad_out), 32'(r.sad));
          chk("under_th", 32'(under_th), 32'(r.under));
          chk("extended", 32'(extended), 32'(r.ext));
          if (r.lat >= 0) chk("done_latency", 32'(cyc - st_cyc), 32'(r.lat));
        end
      end
    end
  end

  task automatic set_in(input logic [13:0] a, input logic [13:0] b, input logic [13:0] t,
                        input logic [13:0] u0, input logic [13:0] u1, input bit ff,
                        input bit ee, input int th);
    cand_sp_a = a;
    cand_sp_b = b;
    cand_tmp = t;
    upd_vec = {u1, u0};
    first_frame = ff;
    ext_en = ee;
    sad_th = 16'(th);
  endtask

  task automatic expect_res(input logic [13:0] m, input int s, input bit u, input bit e,
                            input int lat);
    res_t r;
    r.mv = m;
    r.sad = 16'(s);
    r.under = u;
    r.ext = e;
    r.lat = lat;
    exp_res_q.push_back(r);
  endtask

  task automatic plan(input int s0, input int s1, input int s2, input int s3, input int s4);
    sad_plan.push_back(16'(s0));
    sad_plan.push_back(16'(s1));
    sad_plan.push_back(16'(s2));
    sad_plan.push_back(16'(s3));
    if (s4 >= 0) sad_plan.push_back(16'(s4));
  endtask

  // Pulse start and wait (bounded) for the expected result; optional pokes of start while busy
  task automatic run_block(input bit poke);
    int n;
    st_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((exp_res_q.size() != 0) && (n < 300)) begin
      start = poke && ((n == 2) || (n == 9));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (exp_res_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL block_timeout: got no done after %0d cycles, expected done", n);
      exp_res_q.delete();
      exp_cand_q.delete();
      sad_plan.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("cands_left", 32'(exp_cand_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b1;
    cand_ready = 1'b1;
    sad_valid = 1'b0;
    sad_in = '0;
    set_in(mv(3, -2), mv(1, 1), mv(2, 2), mv(1, 1), mv(1, 1), 1'b0, 1'b0, 0);

    // Reset held with start=1
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cand_valid", 32'(cand_valid), 32'd0);
    chk("rst_cand_mv", 32'(cand_mv), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mv_out", 32'(mv_out), 32'd0);
    chk("rst_sad_out", 32'(sad_out), 32'd0);
    chk("rst_under_th", 32'(under_th), 32'd0);
    chk("rst_extended", 32'(extended), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cand_valid", 32'(cand_valid), 32'd0);

    // Base pass, best is upd1 = (3,-2)+(-1,1) = (2,-1); extra starts while busy are ignored
    set_in(mv(3, -2), mv(0, 4), mv(-5, 1), mv(2, 2), mv(-1, 1), 1'b0, 1'b1, 100);
    exp_cand_q.push_back(mv(3, -2));
    exp_cand_q.push_back(mv(0, 4));
    exp_cand_q.push_back(mv(-5, 1));
    exp_cand_q.push_back(mv(5, 0));
    exp_cand_q.push_back(mv(2, -1));
    plan(50, 40, 40, 60, 10);
    expect_res(mv(2, -1), 10, 1'b1, 1'b0, 10);
    run_block(1'b1);

    // Tie keeps sp_a; SAD equal to threshold is not under it
    set_in(mv(1, 1), mv(2, 2), mv(0, 0), mv(0, 0), mv(1, 0), 1'b0, 1'b0, 20);
    exp_cand_q.push_back(mv(1, 1));
    exp_cand_q.push_back(mv(2, 2));
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(1, 1));
    exp_cand_q.push_back(mv(2, 1));
    plan(20, 20, 30, 25, 40);
    expect_res(mv(1, 1), 20, 1'b0, 1'b0, 10);
    run_block(1'b0);

    // First frame: spatial/temporal forced to zero, updates offset from zero
    set_in(mv(4, -4), mv(5, 5), mv(-6, 2), mv(1, 2), mv(-3, 0), 1'b1, 1'b0, 100);
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(1, 2));
    exp_cand_q.push_back(mv(-3, 0));
    plan(9, 8, 7, 6, 5);
    expect_res(mv(-3, 0), 5, 1'b1, 1'b0, 10);
    run_block(1'b0);

    // Clipping: saturates at +/-16 with no wrap, even for sums beyond the 7-bit range
    set_in(mv(15, -15), mv(60, -60), mv(0, 0), mv(3, -3), mv(63, -64), 1'b0, 1'b0, 200);
    exp_cand_q.push_back(mv(15, -15));
    exp_cand_q.push_back(mv(16, -16));
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(16, -16));
    exp_cand_q.push_back(mv(16, -16));
    plan(100, 90, 80, 70, 70);
    expect_res(mv(16, -16), 70, 1'b1, 1'b0, 10);
    run_block(1'b0);

    // Extended pass around best (16,0) SAD 30 with th=5; (15,0) then wins with 25
    set_in(mv(16, 0), mv(0, 3), mv(-2, -2), mv(1, 1), mv(0, -1), 1'b0, 1'b1, 5);
    exp_cand_q.push_back(mv(16, 0));
    exp_cand_q.push_back(mv(0, 3));
    exp_cand_q.push_back(mv(-2, -2));
    exp_cand_q.push_back(mv(16, 1));
    exp_cand_q.push_back(mv(16, -1));
    exp_cand_q.push_back(mv(16, 0));
    exp_cand_q.push_back(mv(15, 0));
    exp_cand_q.push_back(mv(16, 1));
    exp_cand_q.push_back(mv(16, -1));
    plan(30, 40, 50, 60, 70);
    plan(35, 25, 45, 30, -1);
    expect_res(mv(15, 0), 25, 1'b0, 1'b1, -1);
    run_block(1'b0);

    // Random backpressure over a full block
    rand_ready = 1'b1;
    set_in(mv(3, -2), mv(0, 4), mv(-5, 1), mv(2, 2), mv(-1, 1), 1'b0, 1'b0, 100);
    exp_cand_q.push_back(mv(3, -2));
    exp_cand_q.push_back(mv(0, 4));
    exp_cand_q.push_back(mv(-5, 1));
    exp_cand_q.push_back(mv(5, 0));
    exp_cand_q.push_back(mv(2, -1));
    plan(50, 40, 40, 60, 10);
    expect_res(mv(2, -1), 10, 1'b1, 1'b0, -1);
    run_block(1'b0);

    // Backpressure then reset while draining: the block is abandoned, no done
    set_in(mv(1, 1), mv(2, 2), mv(0, 0), mv(0, 0), mv(1, 0), 1'b0, 1'b0, 20);
    exp_cand_q.push_back(mv(1, 1));
    exp_cand_q.push_back(mv(2, 2));
    exp_cand_q.push_back(mv(0, 0));
    exp_cand_q.push_back(mv(1, 1));
    exp_cand_q.push_back(mv(2, 1));
    plan(20, 20, 30, 25, 40);
    expect_res(mv(1, 1), 20, 1'b0, 1'b0, -1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((exp_cand_q.size() != 0) && (n < 300)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_reached", 32'(exp_cand_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    exp_res_q.delete();
    exp_cand_q.delete();
    sad_plan.delete();
    rand_ready = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mv_out", 32'(mv_out), 32'd0);
    chk("mid_rst_sad_out", 32'(sad_out), 32'd0);
    chk("mid_rst_under_th", 32'(under_th), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("after_rst_busy", 32'(busy), 32'd0);
    chk("after_rst_cand_valid", 32'(cand_valid), 32'd0);
    chk("after_rst_mv_out", 32'(mv_out), 32'd0);
    chk("after_rst_sad_out", 32'(sad_out), 32'd0);
    chk("after_rst_extended", 32'(extended), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
